// File: rtl/serial_adder_if.sv
// Operand/request and result/flag bundle for the bit-serial add/subtract unit.
// The requester drives the master side and the adder is the slave.
interface serial_adder_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, A, B, sub,
        input  busy, done, result, negative, zero, carry_out, overflow
    );

    modport slave (
        input  start, A, B, sub,
        output busy, done, result, negative, zero, carry_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one full-adder cell and one carry flop.
// The result and the N/Z/C/V flags are registered and change only on completion or reset.
//
// state | meaning
// IDLE  | waiting for start; result/flags hold
// RUN   | one operand bit per clock, WIDTH clocks
// DONE  | one-cycle done pulse; start here restarts without a gap
module serial_adder #(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] sr_shift;

    // Full-adder cell on the current LSBs and the carry flop.
    assign fa_s     = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign fa_c     = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    assign sr_shift = {fa_s, sr_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            sr_q      <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            sr_q      <= sr_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sr_d      = sr_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
                    sa_d    = bus.A;
                    sb_d    = bus.B ^ {WIDTH{bus.sub}};
                    sr_d    = '0;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sr_d    = sr_shift;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 2)) begin
                    cin_msb_d = fa_c;
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = sr_shift;
                    neg_d    = fa_s;
                    zero_d   = (sr_shift == '0);
                    cout_d   = fa_c;
                    ovf_d    = fa_c ^ cin_msb_q;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=64: arithmetic vectors with hand-computed
// results/flags, plus start-during-RUN, back-to-back and mid-RUN reset corners.
module tb_serial_adder;
    localparam int W = 64;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one start (edge E0), then scrambles the operands and waits for done.
    task automatic launch_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output int busy_cnt, output bit got_done);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.sub   = s;
        step();
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = a ^ b ^ 64'h5A5A_A5A5_0F0F_F0F0;
        bus.sub   = ~s;
        busy_cnt  = 0;
        got_done  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.sub   = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        total++;
        if ({bus.negative, bus.zero, bus.carry_out, bus.overflow} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.negative, bus.zero, bus.carry_out, bus.overflow});
        end
        step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_arith(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s, input logic [W-1:0] exp_r, input logic [3:0] exp_nzcv);
        int bc;
        bit gd;
        launch_and_wait(a, b, s, bc, gd);
        total++; if (!gd) begin bad++; $display("FAIL %s_done_timeout got=no_done exp=done", name); end
        total++; if (bc !== W) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, W); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_busy_in_done got=%b exp=0", name, bus.busy); end
        total++; if (bus.result !== exp_r) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, bus.result, exp_r); end
        total++;
        if ({bus.negative, bus.zero, bus.carry_out, bus.overflow} !== exp_nzcv) begin
            bad++;
            $display("FAIL %s_nzcv got=%b exp=%b", name, {bus.negative, bus.zero, bus.carry_out, bus.overflow}, exp_nzcv);
        end
        step();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done_width got=%b exp=0", name, bus.done); end
        step();
        step();
        total++; if (bus.result !== exp_r) begin bad++; $display("FAIL %s_hold got=%h exp=%h", name, bus.result, exp_r); end
    endtask

    task automatic test_start_ignored();
        int bc;
        bus.start = 1'b1; bus.A = 64'd10; bus.B = 64'd20; bus.sub = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.start = 1'b1; bus.A = 64'd1000; bus.B = 64'd1; bus.sub = 1'b1;
        step();
        bus.start = 1'b0;
        bc = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) break;
            if (bus.busy) bc++;
            step();
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ignore_done got=%b exp=1", bus.done); end
        total++; if (bc !== W - 10) begin bad++; $display("FAIL ignore_busy_rest got=%0d exp=%0d", bc, W - 10); end
        total++; if (bus.result !== 64'd30) begin bad++; $display("FAIL ignore_result got=%h exp=1e", bus.result); end
        step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int bc;
        bit gd;
        launch_and_wait(64'd100, 64'd1, 1'b1, bc, gd);
        total++; if (!gd) begin bad++; $display("FAIL b2b_first_timeout got=no_done exp=done"); end
        total++; if (bus.result !== 64'd99) begin bad++; $display("FAIL b2b_first_result got=%h exp=63", bus.result); end
        bus.start = 1'b1; bus.A = 64'd7; bus.B = 64'd9; bus.sub = 1'b0;
        step();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap got=%b exp=1", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%b exp=0", bus.done); end
        total++; if (bus.result !== 64'd99) begin bad++; $display("FAIL b2b_hold_in_run got=%h exp=63", bus.result); end
        bc = 0;
        gd = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin gd = 1'b1; break; end
            if (bus.busy) bc++;
            step();
        end
        total++; if (!gd) begin bad++; $display("FAIL b2b_second_timeout got=no_done exp=done"); end
        total++; if (bc !== W) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", bc, W); end
        total++; if (bus.result !== 64'd16) begin bad++; $display("FAIL b2b_second_result got=%h exp=10", bus.result); end
        step();
    endtask

    task automatic test_reset_midrun();
        bit seen_done;
        bus.start = 1'b1; bus.A = 64'd5; bus.B = 64'd3; bus.sub = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (29) step();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b exp=1", bus.busy); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrun_rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.result !== 64'd0) begin bad++; $display("FAIL midrun_rst_result got=%h exp=0", bus.result); end
        total++;
        if ({bus.negative, bus.zero, bus.carry_out, bus.overflow} !== 4'b0000) begin
            bad++;
            $display("FAIL midrun_rst_flags got=%b exp=0000", {bus.negative, bus.zero, bus.carry_out, bus.overflow});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.done || bus.busy) seen_done = 1'b1;
            step();
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL midrun_no_done got=%b exp=0", seen_done); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_arith("add",    64'd5, 64'd3, 1'b0, 64'd8, 4'b0000);
        test_arith("sub_eq", 64'd5, 64'd5, 1'b1, 64'd0, 4'b0110);
        test_arith("sovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
        test_arith("borrow", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
        test_arith("uwrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110);
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
